// File: rtl/combat_resolver.sv
// combat_resolver: frame-timed two-player hit resolver (attack FSMs, block, hitstun, health, KO/winner)
// Ports: clk; rst_n async active-low; frame_tick per-frame strobe; round_start sync reinit;
//   p1_atk/p1_blk/p2_atk/p2_blk player controls; hit_overlap from the collision unit;
//   p1_state/p2_state FSM state; p1_health/p2_health; hit_p1_to_p2/hit_p2_to_p1/blocked pulses;
//   ko level and winner (01 P1, 10 P2, 11 draw).
// Option: define CHIP_DAMAGE_EN to make blocked hits cost CHIP_DMG health.
module combat_resolver #(
    parameter int HP_W       = 8,
    parameter int MAX_HP     = 100,
    parameter int DMG        = 10,
    parameter int CHIP_DMG   = 1,
    parameter int STARTUP_F  = 3,
    parameter int ACTIVE_F   = 2,
    parameter int RECOVERY_F = 6,
    parameter int HITSTUN_F  = 8,
    parameter int FRM_W      = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            frame_tick,
    input  logic            round_start,
    input  logic            p1_atk,
    input  logic            p1_blk,
    input  logic            p2_atk,
    input  logic            p2_blk,
    input  logic            hit_overlap,
    output logic [2:0]      p1_state,
    output logic [2:0]      p2_state,
    output logic [HP_W-1:0] p1_health,
    output logic [HP_W-1:0] p2_health,
    output logic            hit_p1_to_p2,
    output logic            hit_p2_to_p1,
    output logic [1:0]      blocked,
    output logic            ko,
    output logic [1:0]      winner
);
    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_STARTUP  = 3'd1;
    localparam logic [2:0] S_ACTIVE   = 3'd2;
    localparam logic [2:0] S_RECOVERY = 3'd3;
    localparam logic [2:0] S_HITSTUN  = 3'd4;
    localparam logic [2:0] S_BLOCK    = 3'd5;
    localparam logic [2:0] S_KO       = 3'd6;
    localparam logic [FRM_W-1:0] F_ZERO     = '0;
    localparam logic [FRM_W-1:0] F_ONE      = FRM_W'(1);
    localparam logic [FRM_W-1:0] F_STARTUP  = FRM_W'(STARTUP_F - 1);
    localparam logic [FRM_W-1:0] F_ACTIVE   = FRM_W'(ACTIVE_F - 1);
    localparam logic [FRM_W-1:0] F_RECOVERY = FRM_W'(RECOVERY_F - 1);
    localparam logic [FRM_W-1:0] F_HITSTUN  = FRM_W'(HITSTUN_F - 1);
    localparam logic [HP_W-1:0]  HP_MAX     = HP_W'(MAX_HP);
    localparam logic [HP_W-1:0]  HP_DMG     = HP_W'(DMG);
    localparam logic [HP_W-1:0]  HP_CHIP    = HP_W'(CHIP_DMG);
`ifdef CHIP_DAMAGE_EN
    localparam logic CHIP_ON = 1'b1;
`else
    localparam logic CHIP_ON = 1'b0;
`endif

    logic [FRM_W-1:0] p1_cnt, p2_cnt, p1_cnt_nx, p2_cnt_nx;
    logic [2:0]       p1_st_nx, p2_st_nx;
    logic [HP_W-1:0]  p1_hp_nx, p2_hp_nx;
    logic             p1_conn, p2_conn, p1_conn_nx, p2_conn_nx;
    logic             p1_lands, p2_lands, p1_guard, p2_guard, p1_hit, p2_hit, any_ko;
    logic             ko_nx;
    logic [1:0]       winner_nx;

    // Unhit phase progression: returns {state, counter}; counters load length-1 and exit at 0.
    function automatic logic [FRM_W+2:0] step(input logic [2:0] st, input logic [FRM_W-1:0] c,
                                              input logic atk, input logic blk);
        logic last;
        last = (c == F_ZERO);
        case (st)
            S_IDLE, S_BLOCK:       step = atk ? {S_STARTUP, F_STARTUP} : {(blk ? S_BLOCK : S_IDLE), F_ZERO};
            S_STARTUP:             step = last ? {S_ACTIVE, F_ACTIVE} : {st, c - F_ONE};
            S_ACTIVE:              step = last ? {S_RECOVERY, F_RECOVERY} : {st, c - F_ONE};
            S_RECOVERY, S_HITSTUN: step = last ? {S_IDLE, F_ZERO} : {st, c - F_ONE};
            default:               step = {st, c};
        endcase
    endfunction

    function automatic logic [HP_W-1:0] sub_sat(input logic [HP_W-1:0] hp, input logic [HP_W-1:0] d);
        sub_sat = (hp > d) ? hp - d : '0;
    endfunction

    // Next-state: hit resolution uses the pre-tick states, so a trade damages both players.
    always_comb begin
        p1_lands   = p1_state == S_ACTIVE && hit_overlap && !p1_conn;
        p2_lands   = p2_state == S_ACTIVE && hit_overlap && !p2_conn;
        p1_guard   = p2_lands && p1_state == S_BLOCK;
        p2_guard   = p1_lands && p2_state == S_BLOCK;
        p1_hit     = p2_lands && !p1_guard;
        p2_hit     = p1_lands && !p2_guard;
        p1_hp_nx   = sub_sat(p1_health, p1_hit ? HP_DMG : (p1_guard && CHIP_ON) ? HP_CHIP : '0);
        p2_hp_nx   = sub_sat(p2_health, p2_hit ? HP_DMG : (p2_guard && CHIP_ON) ? HP_CHIP : '0);
        any_ko     = p1_hp_nx == '0 || p2_hp_nx == '0;
        {p1_st_nx, p1_cnt_nx} = any_ko ? {S_KO, F_ZERO} : p1_hit ? {S_HITSTUN, F_HITSTUN} :
                                p1_guard ? {S_BLOCK, p1_cnt} : step(p1_state, p1_cnt, p1_atk, p1_blk);
        {p2_st_nx, p2_cnt_nx} = any_ko ? {S_KO, F_ZERO} : p2_hit ? {S_HITSTUN, F_HITSTUN} :
                                p2_guard ? {S_BLOCK, p2_cnt} : step(p2_state, p2_cnt, p2_atk, p2_blk);
        // connected clears whenever a new attack starts from IDLE/BLOCK
        p1_conn_nx = p1_lands || (p1_conn && !((p1_state == S_IDLE || p1_state == S_BLOCK) && p1_atk));
        p2_conn_nx = p2_lands || (p2_conn && !((p2_state == S_IDLE || p2_state == S_BLOCK) && p2_atk));
    end

    // Winner bits: [1] set when P2 survives (P1 emptied), [0] when P1 survives; both set is a draw.
    always_comb begin
        winner_nx = {p1_hp_nx == '0, p2_hp_nx == '0};
        ko_nx     = |winner_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p1_state     <= S_IDLE;
            p2_state     <= S_IDLE;
            p1_cnt       <= F_ZERO;
            p2_cnt       <= F_ZERO;
            p1_conn      <= 1'b0;
            p2_conn      <= 1'b0;
            p1_health    <= HP_MAX;
            p2_health    <= HP_MAX;
            hit_p1_to_p2 <= 1'b0;
            hit_p2_to_p1 <= 1'b0;
            blocked      <= 2'b00;
            ko           <= 1'b0;
            winner       <= 2'b00;
        end else if (round_start) begin
            p1_state     <= S_IDLE;
            p2_state     <= S_IDLE;
            p1_cnt       <= F_ZERO;
            p2_cnt       <= F_ZERO;
            p1_conn      <= 1'b0;
            p2_conn      <= 1'b0;
            p1_health    <= HP_MAX;
            p2_health    <= HP_MAX;
            hit_p1_to_p2 <= 1'b0;
            hit_p2_to_p1 <= 1'b0;
            blocked      <= 2'b00;
            ko           <= 1'b0;
            winner       <= 2'b00;
        end else begin
            hit_p1_to_p2 <= 1'b0;
            hit_p2_to_p1 <= 1'b0;
            blocked      <= 2'b00;
            if (frame_tick && !ko) begin
                p1_state     <= p1_st_nx;
                p2_state     <= p2_st_nx;
                p1_cnt       <= p1_cnt_nx;
                p2_cnt       <= p2_cnt_nx;
                p1_conn      <= p1_conn_nx;
                p2_conn      <= p2_conn_nx;
                p1_health    <= p1_hp_nx;
                p2_health    <= p2_hp_nx;
                hit_p1_to_p2 <= p2_hit;
                hit_p2_to_p1 <= p1_hit;
                blocked      <= {p2_guard, p1_guard};
                ko           <= ko_nx;
                winner       <= winner_nx;
            end
        end
    end
endmodule

// File: tb/tb_combat_resolver.sv
// tb_combat_resolver: directed vectors and hand sequences for combat_resolver
module tb_combat_resolver;
    logic clk = 1'b0, rst_n = 1'b0, frame_tick = 1'b0, round_start = 1'b0;
    logic p1_atk = 1'b0, p1_blk = 1'b0, p2_atk = 1'b0, p2_blk = 1'b0, hit_overlap = 1'b0;
    logic [2:0] p1_state, p2_state;
    logic [7:0] p1_health, p2_health;
    logic       hit_p1_to_p2, hit_p2_to_p1, ko;
    logic [1:0] blocked, winner;
    int n_cmp = 0, n_err = 0;

    localparam logic [2:0] ID = 3'd0, SU = 3'd1, AC = 3'd2, RC = 3'd3, HS = 3'd4, BK = 3'd5, KO = 3'd6;
    localparam logic [7:0] H100 = 8'd100, H90 = 8'd90, H10 = 8'd10, H0 = 8'd0;
`ifdef CHIP_DAMAGE_EN
    localparam logic [7:0] HBLK = 8'd99;
`else
    localparam logic [7:0] HBLK = 8'd100;
`endif

    typedef struct {
        logic rs, t, a1, b1, a2, b2, ov;
        logic [2:0] s1, s2;
        logic [7:0] h1, h2;
        logic x12, x21;
        logic [1:0] bl;
    } vec_t;
    vec_t tbl [22];

    always #5 clk = ~clk;

    combat_resolver dut (
        .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .round_start(round_start),
        .p1_atk(p1_atk), .p1_blk(p1_blk), .p2_atk(p2_atk), .p2_blk(p2_blk), .hit_overlap(hit_overlap),
        .p1_state(p1_state), .p2_state(p2_state), .p1_health(p1_health), .p2_health(p2_health),
        .hit_p1_to_p2(hit_p1_to_p2), .hit_p2_to_p1(hit_p2_to_p1), .blocked(blocked), .ko(ko), .winner(winner)
    );

    function automatic vec_t mk(input logic rs, t, a1, b1, a2, b2, ov, input logic [2:0] s1, s2,
                                input logic [7:0] h1, h2, input logic x12, x21, input logic [1:0] bl);
        mk = '{rs, t, a1, b1, a2, b2, ov, s1, s2, h1, h2, x12, x21, bl};
    endfunction

    task automatic cyc(input logic t, rs, a1, b1, a2, b2, ov);
        @(negedge clk);
        frame_tick = t; round_start = rs; p1_atk = a1; p1_blk = b1; p2_atk = a2; p2_blk = b2; hit_overlap = ov;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [2:0] s1, s2, input logic [7:0] h1, h2,
                       input logic x12, x21, input logic [1:0] bl, input logic k, input logic [1:0] w);
        n_cmp++;
        if ({p1_state, p2_state, p1_health, p2_health, hit_p1_to_p2, hit_p2_to_p1, blocked, ko, winner}
            !== {s1, s2, h1, h2, x12, x21, bl, k, w}) begin
            n_err++;
            $display("FAIL %s: got st=%0d/%0d hp=%0d/%0d hit=%b%b blk=%b ko=%b win=%b; want st=%0d/%0d hp=%0d/%0d hit=%b%b blk=%b ko=%b win=%b",
                     nm, p1_state, p2_state, p1_health, p2_health, hit_p1_to_p2, hit_p2_to_p1, blocked, ko, winner,
                     s1, s2, h1, h2, x12, x21, bl, k, w);
        end
    endtask

    task automatic wait_hit(input string nm, input logic a1, a2);
        logic got;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            cyc(1, 0, a1, 0, a2, 0, 1);
            got = hit_p1_to_p2 | hit_p2_to_p1;
        end
        n_cmp++;
        if (!got) begin
            n_err++;
            $display("FAIL %s: hit pulse got 0 want 1 within 40 frames", nm);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        #12;
        chk("reset", ID, ID, H100, H100, 0, 0, 2'b00, 0, 2'b00);
        @(negedge clk);
        rst_n = 1'b1;
        // P1 attack into idle P2 with overlap held, then round_start, then attack into blocking P2
        tbl[0]  = mk(0, 1, 1, 0, 0, 0, 1, SU, ID, H100, H100, 0, 0, 2'b00);
        tbl[1]  = mk(0, 1, 0, 0, 0, 0, 1, SU, ID, H100, H100, 0, 0, 2'b00);
        tbl[2]  = mk(0, 1, 0, 0, 0, 0, 1, SU, ID, H100, H100, 0, 0, 2'b00);
        tbl[3]  = mk(0, 0, 0, 0, 0, 0, 1, SU, ID, H100, H100, 0, 0, 2'b00);
        tbl[4]  = mk(0, 1, 0, 0, 0, 0, 1, AC, ID, H100, H100, 0, 0, 2'b00);
        tbl[5]  = mk(0, 1, 0, 0, 0, 0, 1, AC, HS, H100, H90,  1, 0, 2'b00);
        tbl[6]  = mk(0, 0, 0, 0, 0, 0, 1, AC, HS, H100, H90,  0, 0, 2'b00);
        tbl[7]  = mk(0, 1, 0, 0, 0, 0, 1, RC, HS, H100, H90,  0, 0, 2'b00);
        for (int i = 8; i <= 12; i++) tbl[i] = mk(0, 1, 0, 0, 0, 0, 1, RC, HS, H100, H90, 0, 0, 2'b00);
        tbl[13] = mk(0, 1, 0, 0, 0, 0, 1, ID, HS, H100, H90,  0, 0, 2'b00);
        tbl[14] = mk(0, 1, 0, 0, 0, 0, 1, ID, ID, H100, H90,  0, 0, 2'b00);
        tbl[15] = mk(1, 1, 1, 0, 0, 0, 1, ID, ID, H100, H100, 0, 0, 2'b00);
        tbl[16] = mk(0, 1, 1, 0, 0, 1, 1, SU, BK, H100, H100, 0, 0, 2'b00);
        tbl[17] = mk(0, 1, 0, 0, 0, 1, 1, SU, BK, H100, H100, 0, 0, 2'b00);
        tbl[18] = mk(0, 1, 0, 0, 0, 1, 1, SU, BK, H100, H100, 0, 0, 2'b00);
        tbl[19] = mk(0, 1, 0, 0, 0, 1, 1, AC, BK, H100, H100, 0, 0, 2'b00);
        tbl[20] = mk(0, 1, 0, 0, 0, 1, 1, AC, BK, H100, HBLK, 0, 0, 2'b10);
        tbl[21] = mk(0, 1, 0, 0, 0, 1, 1, RC, BK, H100, HBLK, 0, 0, 2'b00);
        for (int i = 0; i < 22; i++) begin
            cyc(tbl[i].t, tbl[i].rs, tbl[i].a1, tbl[i].b1, tbl[i].a2, tbl[i].b2, tbl[i].ov);
            chk($sformatf("vec%0d", i), tbl[i].s1, tbl[i].s2, tbl[i].h1, tbl[i].h2,
                tbl[i].x12, tbl[i].x21, tbl[i].bl, 0, 2'b00);
        end
        // trade
        cyc(0, 1, 0, 0, 0, 0, 0);
        cyc(1, 0, 1, 0, 1, 0, 0);
        chk("trade startup", SU, SU, H100, H100, 0, 0, 2'b00, 0, 2'b00);
        repeat (2) cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0);
        chk("trade active", AC, AC, H100, H100, 0, 0, 2'b00, 0, 2'b00);
        cyc(1, 0, 0, 0, 0, 0, 1);
        chk("trade hit", HS, HS, H90, H90, 1, 1, 2'b00, 0, 2'b00);
        cyc(1, 0, 0, 0, 0, 0, 1);
        chk("trade no rehit", HS, HS, H90, H90, 0, 0, 2'b00, 0, 2'b00);
        repeat (8) cyc(1, 0, 0, 0, 0, 0, 0);
        chk("trade recover", ID, ID, H90, H90, 0, 0, 2'b00, 0, 2'b00);
        // asynchronous reset while P1 is ACTIVE
        cyc(1, 0, 1, 0, 0, 0, 0);
        repeat (3) cyc(1, 0, 0, 0, 0, 0, 0);
        chk("pre-reset active", AC, ID, H90, H90, 0, 0, 2'b00, 0, 2'b00);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk("async reset", ID, ID, H100, H100, 0, 0, 2'b00, 0, 2'b00);
        @(negedge clk);
        rst_n = 1'b1;
        // P1 wins by KO
        for (int k = 0; k < 9; k++) wait_hit($sformatf("p1 hit %0d", k), 1, 0);
        chk("p2 at 10", AC, HS, H100, H10, 1, 0, 2'b00, 0, 2'b00);
        wait_hit("p1 final hit", 1, 0);
        chk("p1 ko win", KO, KO, H100, H0, 1, 0, 2'b00, 1, 2'b01);
        repeat (3) cyc(1, 0, 1, 0, 1, 0, 1);
        chk("ko frozen", KO, KO, H100, H0, 0, 0, 2'b00, 1, 2'b01);
        cyc(1, 1, 1, 0, 0, 0, 1);
        chk("round restart", ID, ID, H100, H100, 0, 0, 2'b00, 0, 2'b00);
        // both at 10 HP, trade -> draw
        for (int k = 0; k < 9; k++) wait_hit($sformatf("p2 hit %0d", k), 0, 1);
        repeat (10) cyc(1, 0, 0, 0, 0, 0, 0);
        chk("p1 at 10", ID, ID, H10, H100, 0, 0, 2'b00, 0, 2'b00);
        for (int k = 0; k < 9; k++) wait_hit($sformatf("p1b hit %0d", k), 1, 0);
        repeat (10) cyc(1, 0, 0, 0, 0, 0, 0);
        chk("both at 10", ID, ID, H10, H10, 0, 0, 2'b00, 0, 2'b00);
        cyc(1, 0, 1, 0, 1, 0, 1);
        repeat (2) cyc(1, 0, 0, 0, 0, 0, 1);
        cyc(1, 0, 0, 0, 0, 0, 1);
        chk("draw active", AC, AC, H10, H10, 0, 0, 2'b00, 0, 2'b00);
        cyc(1, 0, 0, 0, 0, 0, 1);
        chk("draw ko", KO, KO, H0, H0, 1, 1, 2'b00, 1, 2'b11);
        cyc(1, 0, 0, 0, 0, 0, 1);
        chk("draw held", KO, KO, H0, H0, 0, 0, 2'b00, 1, 2'b11);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
